// File: rtl/wb_master_if.sv
// Wishbone classic initiator: one valid/ready request becomes one bus cycle and one response.
// Latency: stb rises on the accept edge; the response is valid on the edge that samples ack/err/timeout.
// Backpressure: single outstanding; req_ready_o stays low until the response is taken by rsp_ready_i.
module wb_master_if #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_data_i,
  input  logic                     req_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  req_sel_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  output logic                     busy_o
);

  // Counter must hold 0..TIMEOUT-1; keep at least one bit so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CNT_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LAST_INT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     req_ready_d;
  logic                     rsp_valid_d;
  logic [WB_DATA_WIDTH-1:0] rsp_data_d;
  logic                     rsp_err_d;
  logic [WB_ADDR_WIDTH-1:0] wb_addr_d;
  logic [WB_DATA_WIDTH-1:0] wb_data_d;
  logic                     wb_we_d;
  logic [WB_SEL_WIDTH-1:0]  wb_sel_d;
  logic                     wb_stb_d;
  logic                     wb_cyc_d;
  logic                     busy_d;
  logic                     bus_done;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_o;
    rsp_valid_d = rsp_valid_o;
    rsp_data_d  = rsp_data_o;
    rsp_err_d   = rsp_err_o;
    wb_addr_d   = wb_addr_o;
    wb_data_d   = wb_data_o;
    wb_we_d     = wb_we_o;
    wb_sel_d    = wb_sel_o;
    wb_stb_d    = wb_stb_o;
    wb_cyc_d    = wb_cyc_o;
    bus_done    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        // Acceptance uses the registered ready, so the first edge after reset only raises ready.
        if (req_valid_i && req_ready_o) begin
          wb_addr_d   = req_addr_i;
          wb_data_d   = req_we_i ? req_data_i : '0;
          wb_we_d     = req_we_i;
          wb_sel_d    = req_sel_i;
          wb_cyc_d    = 1'b1;
          wb_stb_d    = 1'b1;
          req_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          // Error takes priority over a simultaneous ack.
          bus_done   = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (wb_ack_i) begin
          bus_done   = 1'b1;
          rsp_err_d  = 1'b0;
          rsp_data_d = wb_we_o ? '0 : wb_data_i;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          bus_done   = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bus_done) begin
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        wb_cyc_d    = 1'b0;
        wb_stb_d    = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers; reset aborts any cycle without a response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_o <= req_ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
      rsp_err_o   <= rsp_err_d;
      wb_addr_o   <= wb_addr_d;
      wb_data_o   <= wb_data_d;
      wb_we_o     <= wb_we_d;
      wb_sel_o    <= wb_sel_d;
      wb_stb_o    <= wb_stb_d;
      wb_cyc_o    <= wb_cyc_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_master_if.sv
// Bench for wb_master_if: directed scenarios then randomized transactions against a reference model.
// Latency: model predicts stb length, response data/err and ready timing per transaction.
// Backpressure: response stalls are randomized and checked for stability.
module tb_wb_master_if;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        req_we_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_data_i;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  wb_master_if #(
    .WB_DATA_WIDTH(32),
    .WB_ADDR_WIDTH(32),
    .WB_SEL_WIDTH (4),
    .TIMEOUT      (TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .req_we_i   (req_we_i),
    .req_sel_i  (req_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_data_i  (wb_data_i),
    .busy_o     (busy_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction. mode: 0 ack, 1 err, 2 ack+err together, 3 slave silent.
  // dly: stb cycles before the slave responds; stall: cycles the requester holds rsp_ready_i low.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic [3:0] sel, input int dly, input int mode,
                     input logic [31:0] rd, input int stall);
    bit          timed_out;
    int          k_exp;
    int          k;
    int          w;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [31:0] exp_wd;

    timed_out = (mode == 3) || (dly + 1 > TO);
    k_exp     = timed_out ? TO : dly + 1;
    exp_err   = timed_out || (mode == 1) || (mode == 2);
    exp_dat   = (!exp_err && !we) ? rd : 32'h0;
    exp_wd    = we ? d : 32'h0;

    w = 0;
    while (!req_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    chk("req_ready_idle", req_ready_o, 1'b1);

    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    req_we_i    = we;
    req_sel_i   = sel;
    @(negedge clk_i);
    // Scramble the request fields; they must not reach the bus now.
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_data_i  = $urandom;
    req_we_i    = 1'($urandom);
    req_sel_i   = 4'($urandom);
    chk("req_ready_busy", {req_ready_o, busy_o}, 2'b01);

    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wb_stb_o) break;
      k++;
      chk("wb_hold", {wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_cyc_o, rsp_valid_o},
          {a, exp_wd, we, sel, 1'b1, 1'b0});
      if (mode != 3 && k == dly + 1) begin
        wb_ack_i  = (mode != 1);
        wb_err_i  = (mode != 0);
        wb_data_i = rd;
      end else begin
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_data_i = $urandom;
      end
      @(negedge clk_i);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;

    chk("stb_cycles", k, k_exp);
    chk("rsp_first", {wb_cyc_o, rsp_valid_o, rsp_err_o, rsp_data_o}, {1'b0, 1'b1, exp_err, exp_dat});

    for (int i = 0; i < stall; i++) begin
      rsp_ready_i = 1'b0;
      wb_ack_i    = 1'($urandom);
      wb_err_i    = 1'($urandom);
      wb_data_i   = $urandom;
      req_valid_i = 1'($urandom);
      @(negedge clk_i);
      chk("rsp_stall", {rsp_valid_o, rsp_err_o, rsp_data_o, req_ready_o, busy_o, wb_stb_o},
          {1'b1, exp_err, exp_dat, 1'b0, 1'b1, 1'b0});
    end

    rsp_ready_i = 1'b1;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("rsp_taken", {rsp_valid_o, req_ready_o, busy_o}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    int          mode;
    int          r;

    rst_n_i     = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_we_i    = 1'b0;
    req_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    wb_data_i   = '0;

    #1;
    chk("reset_outputs",
        {rsp_data_o, wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
         rsp_valid_o, rsp_err_o, req_ready_o, busy_o}, 128'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("ready_before_edge", req_ready_o, 1'b0);
    @(negedge clk_i);
    chk("ready_after_edge", {req_ready_o, busy_o, rsp_valid_o}, 3'b100);

    // Directed scenarios.
    txn(32'h0000_1000, 32'h0000_0040, 1'b1, 4'hF, 2, 0, 32'h1234_5678, 0);
    txn(32'h0000_2004, 32'h5555_AAAA, 1'b0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0);
    txn(32'h0000_3008, 32'h0, 1'b0, 4'h3, 1, 2, 32'hCAFE_F00D, 0);
    txn(32'h0000_400C, 32'h0, 1'b0, 4'hF, 0, 3, 32'h0, 0);
    txn(32'h0000_5010, 32'h0, 1'b0, 4'hF, 3, 0, 32'h0BAD_F00D, 0);
    txn(32'h0000_6014, 32'h0, 1'b0, 4'hF, 1, 0, 32'h8765_4321, 5);
    txn(32'h0000_7018, 32'h9999_0000, 1'b1, 4'hC, 0, 1, 32'hFFFF_FFFF, 1);

    // Reset in the middle of a bus cycle: no response, immediate drop of the bus.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h0000_8000;
    req_we_i    = 1'b0;
    req_sel_i   = 4'hF;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mid_bus_stb", {wb_cyc_o, wb_stb_o, busy_o}, 3'b111);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_reset_drop", {wb_cyc_o, wb_stb_o, busy_o, rsp_valid_o, req_ready_o}, 5'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_ready", {req_ready_o, rsp_valid_o, wb_cyc_o}, 3'b100);
    @(negedge clk_i);
    chk("no_stale_rsp", {rsp_valid_o, busy_o}, 2'b00);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      a  = $urandom;
      d  = $urandom;
      rd = $urandom;
      r  = $urandom_range(0, 9);
      mode = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
      txn(a, d, 1'($urandom), 4'($urandom), $urandom_range(0, 20), mode, rd,
          $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
